// File: rtl/fifo_rd_stream_adapter_if.sv
// Read-side FIFO signals and the downstream valid/ready stream, grouped for the output adapter.
// master = adapter view, slave = memory/handler plus consumer view.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output r_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  r_en,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Async FIFO read-side output stage: credit-based read issue, 1-cycle memory capture,
// and a small FWFT buffer that isolates consumer back-pressure from the memory read path.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = $clog2(BUF_DEPTH) + 1
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    fifo_rd_stream_adapter_if.master bus,
    output logic [CNT_WIDTH-1:0] buf_count
);

    localparam int PTR_WIDTH = $clog2(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  inflight_q;

    logic [CNT_WIDTH-1:0]  credit_used;
    logic                  valid;
    logic                  deq;

    // Credit counts the in-flight word so the buffer can never overflow; m_ready is not used.
    assign credit_used = count_q + CNT_WIDTH'(inflight_q);
    assign bus.r_en    = !r_rst && !bus.fifo_empty && (credit_used < CNT_WIDTH'(BUF_DEPTH));

    assign valid       = !r_rst && (count_q != '0);
    assign deq         = valid && bus.m_ready;
    assign bus.m_valid = valid;
    assign bus.m_data  = valid ? buf_q[rd_ptr_q] : '0;
    assign buf_count   = count_q;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= bus.r_en;
            if (inflight_q) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_WIDTH'(inflight_q) - CNT_WIDTH'(deq);
        end
    end

    // Data storage needs no reset; occupancy tracking alone decides validity.
    always_ff @(posedge r_clk) begin
        if (!r_rst && inflight_q) begin
            buf_q[wr_ptr_q] <= bus.fifo_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter: source-queue memory model feeding a
// scoreboard of issued words, compared in order as the stream delivers them.
module tb_fifo_rd_stream_adapter;

    localparam int DW = 8;
    localparam int BD = 4;
    localparam int CW = $clog2(BD) + 1;

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic [CW-1:0] buf_count;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream_adapter #(
        .DATA_WIDTH(DW),
        .BUF_DEPTH (BD)
    ) dut (
        .r_clk    (r_clk),
        .r_rst    (r_rst),
        .bus      (bus),
        .buf_count(buf_count)
    );

    always #5 r_clk = ~r_clk;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      ndeq = 0;
    int      first_deq_cyc = 0;
    int      last_deq_cyc = 0;
    int      start_cyc = 0;
    logic [DW-1:0] first_deq_data = '0;
    logic [DW-1:0] src[$];
    logic [DW-1:0] sb[$];
    bit      hold_empty = 1'b1;

    task automatic update_empty();
        bus.fifo_empty = hold_empty || (src.size() == 0);
    endtask

    // One clock cycle: check any handshake, then model the handler/memory response.
    task automatic tick();
        logic          issue;
        logic [DW-1:0] exp;
        #1;
        checks++;
        if (buf_count > BD) begin
            errors++;
            $display("FAIL buf_count_bound: got %0d, max %0d", buf_count, BD);
        end
        if (bus.m_valid && bus.m_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %02h, nothing outstanding", bus.m_data);
            end else begin
                exp = sb.pop_front();
                if (bus.m_data !== exp) begin
                    errors++;
                    $display("FAIL stream_order: got %02h, expected %02h", bus.m_data, exp);
                end
            end
            if (ndeq == 0) begin
                first_deq_cyc  = cyc;
                first_deq_data = bus.m_data;
            end
            last_deq_cyc = cyc;
            ndeq++;
        end
        issue = bus.r_en;
        @(posedge r_clk);
        #1;
        cyc++;
        if (issue) begin
            checks++;
            if (src.size() == 0) begin
                errors++;
                $display("FAIL read_when_empty: r_en=1, source empty");
            end else begin
                bus.fifo_rdata = src.pop_front();
                sb.push_back(bus.fifo_rdata);
            end
        end else begin
            bus.fifo_rdata = DW'($urandom);
        end
        update_empty();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || (!hold_empty && src.size() != 0)) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        r_rst = 1'b1;
        hold_empty = 1'b1;
        bus.m_ready = 1'b1;
        bus.fifo_rdata = '0;
        update_empty();
        repeat (3) tick();
        checks += 4;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.m_valid); end
        if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", bus.m_data); end
        if (bus.r_en !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b, expected 0", bus.r_en); end
        if (buf_count !== 0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", buf_count); end
        r_rst = 1'b0;
        repeat (3) tick();
        checks += 3;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b, expected 0", bus.m_valid); end
        if (bus.r_en !== 1'b0) begin errors++; $display("FAIL idle_ren: got %b, expected 0", bus.r_en); end
        if (buf_count !== 0) begin errors++; $display("FAIL idle_count: got %0d, expected 0", buf_count); end
    endtask

    task automatic test_single();
        ndeq = 0;
        src.push_back(8'hA5);
        hold_empty = 1'b0;
        update_empty();
        #1;
        checks++;
        if (bus.r_en !== 1'b1) begin errors++; $display("FAIL single_ren: got %b, expected 1", bus.r_en); end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b, expected 0", bus.m_valid); end
        tick();
        checks += 3;
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", bus.m_valid); end
        if (bus.m_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h, expected a5", bus.m_data); end
        if (buf_count !== 1) begin errors++; $display("FAIL single_count: got %0d, expected 1", buf_count); end
        tick();
        checks += 3;
        if (ndeq !== 1) begin errors++; $display("FAIL single_delivered: got %0d, expected 1", ndeq); end
        if (buf_count !== 0) begin errors++; $display("FAIL single_count_after: got %0d, expected 0", buf_count); end
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b, expected 0", bus.m_valid); end
    endtask

    task automatic test_stream();
        ndeq = 0;
        for (int i = 1; i <= 16; i++) src.push_back(DW'(i));
        update_empty();
        start_cyc = cyc;
        drain(100);
        checks += 3;
        if (first_deq_cyc - start_cyc != 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d, expected 2", first_deq_cyc - start_cyc);
        end
        if (last_deq_cyc - first_deq_cyc != 15) begin
            errors++;
            $display("FAIL stream_throughput: span %0d cycles, expected 15", last_deq_cyc - first_deq_cyc);
        end
        if (ndeq != 16) begin errors++; $display("FAIL stream_count: got %0d, expected 16", ndeq); end
    endtask

    task automatic test_stall();
        ndeq = 0;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) src.push_back(DW'(i));
        update_empty();
        repeat (10) tick();
        checks += 5;
        if (bus.r_en !== 1'b0) begin errors++; $display("FAIL stall_ren: got %b, expected 0", bus.r_en); end
        if (buf_count !== 4) begin errors++; $display("FAIL stall_count: got %0d, expected 4", buf_count); end
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, expected 1", bus.m_valid); end
        if (bus.m_data !== 8'h01) begin errors++; $display("FAIL stall_data: got %02h, expected 01", bus.m_data); end
        if (src.size() != 12) begin errors++; $display("FAIL stall_issued: got %0d, expected 4", 16 - src.size()); end
        bus.m_ready = 1'b1;
        drain(100);
        checks++;
        if (ndeq != 16) begin errors++; $display("FAIL stall_delivered: got %0d, expected 16", ndeq); end
    endtask

    task automatic test_empty_race();
        ndeq = 0;
        for (int i = 0; i < 5; i++) src.push_back(DW'(8'hC0 + i));
        update_empty();
        tick();
        hold_empty = 1'b1;
        update_empty();
        #1;
        checks++;
        if (bus.r_en !== 1'b0) begin errors++; $display("FAIL race_ren: got %b, expected 0", bus.r_en); end
        drain(20);
        tick();
        checks += 3;
        if (ndeq != 1) begin errors++; $display("FAIL race_delivered: got %0d, expected 1", ndeq); end
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL race_valid_after: got %b, expected 0", bus.m_valid); end
        if (buf_count !== 0) begin errors++; $display("FAIL race_count_after: got %0d, expected 0", buf_count); end
        src.delete();
        hold_empty = 1'b0;
        update_empty();
    endtask

    task automatic test_reset_mid();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) src.push_back(DW'(8'h30 + i));
        update_empty();
        repeat (4) tick();
        checks += 2;
        if (buf_count !== 3) begin errors++; $display("FAIL mid_count_before: got %0d, expected 3", buf_count); end
        if (bus.r_en !== 1'b0) begin errors++; $display("FAIL mid_credit_ren: got %b, expected 0", bus.r_en); end
        r_rst = 1'b1;
        tick();
        checks += 4;
        if (buf_count !== 0) begin errors++; $display("FAIL mid_count_reset: got %0d, expected 0", buf_count); end
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_reset: got %b, expected 0", bus.m_valid); end
        if (bus.r_en !== 1'b0) begin errors++; $display("FAIL mid_ren_reset: got %b, expected 0", bus.r_en); end
        if (bus.m_data !== 8'h00) begin errors++; $display("FAIL mid_data_reset: got %02h, expected 00", bus.m_data); end
        src.delete();
        sb.delete();
        r_rst = 1'b0;
        ndeq = 0;
        for (int i = 0; i < 4; i++) src.push_back(DW'(8'h50 + i));
        bus.m_ready = 1'b1;
        update_empty();
        drain(50);
        checks += 2;
        if (first_deq_data !== 8'h50) begin errors++; $display("FAIL mid_first_word: got %02h, expected 50", first_deq_data); end
        if (ndeq != 4) begin errors++; $display("FAIL mid_delivered: got %0d, expected 4", ndeq); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_empty_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
